// File: rtl/rc_step_responder.sv
// Emulates the RC network and threshold comparator behind the step_set/step_input pins of the RC TDC.
// Optional per-charge threshold jitter is compiled in with `define RC_JITTER_EN.
module rc_step_responder #(
    parameter int          W         = 24,
    parameter int          CAP_PF    = 100,
    parameter int          LN2_X100  = 69,
    parameter int          R_RESET   = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_set,
    input  logic       cfg_valid,
    input  logic [7:0] cfg_r_code,
    output logic       cfg_ready,
    output logic       step_input,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        CHARGING    = 2'd1,
        CHARGED     = 2'd2,
        DISCHARGING = 2'd3
    } rc_state_t;

    localparam logic [63:0] LEVEL_MAX = (64'd1 << W) - 64'd1;

    // Full-width product, saturated to the counter range; zero is forced to one.
    function automatic logic [W-1:0] thresh(input logic [7:0] code);
        logic [63:0] prod;
        prod = 64'(code) * 64'(CAP_PF) * 64'(LN2_X100);
        if (prod == 64'd0)
            return W'(1);
        else if (prod > LEVEL_MAX)
            return LEVEL_MAX[W-1:0];
        else
            return prod[W-1:0];
    endfunction

    localparam logic [W-1:0] TARGET_RST = thresh(8'(R_RESET));

    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero or the jitter LFSR locks up");
    end

    rc_state_t    cur_state, next_state;
    logic [W-1:0] level, level_next;
    logic [W-1:0] target;
    logic [W-1:0] cmp_target;

`ifdef RC_JITTER_EN
    function automatic logic [W-1:0] sat_add(input logic [W-1:0] base, input logic [3:0] jit);
        logic [W:0] sum;
        sum = (W+1)'(base) + (W+1)'(jit);
        return sum[W] ? {W{1'b1}} : sum[W-1:0];
    endfunction

    logic [15:0]  lfsr;
    logic [W-1:0] eff_target;
    logic [W-1:0] start_target;

    assign start_target = sat_add(target, lfsr[3:0]);
    // The jittered threshold is frozen for the whole pulse so charge and discharge times match.
    assign cmp_target   = (cur_state == IDLE) ? start_target : eff_target;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr       <= LFSR_SEED;
            eff_target <= TARGET_RST;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (cur_state == IDLE && step_set)
                eff_target <= start_target;
        end
    end
`else
    assign cmp_target = target;
`endif

    // State register; step_input is registered off the next state for edge-exact hysteresis.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state  <= IDLE;
            step_input <= 1'b0;
        end else begin
            cur_state  <= next_state;
            step_input <= (next_state == CHARGED) || (next_state == DISCHARGING);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level  <= '0;
            target <= TARGET_RST;
        end else begin
            level <= level_next;
            if (cfg_valid && cfg_ready)
                target <= thresh(cfg_r_code);
        end
    end

    // Next-state logic works on the post-edge level.
    always_comb begin
        level_next = level;
        if (step_set && (level < cmp_target))
            level_next = level + W'(1);
        else if (!step_set && (level != '0))
            level_next = level - W'(1);

        next_state = cur_state;
        case (cur_state)
            IDLE: begin
                if (step_set)
                    next_state = (level_next == cmp_target) ? CHARGED : CHARGING;
            end
            CHARGING: begin
                if (level_next == cmp_target)
                    next_state = CHARGED;
                else if (level_next == '0)
                    next_state = IDLE;
            end
            CHARGED: begin
                if (level_next == '0)
                    next_state = IDLE;
                else if (level_next != cmp_target)
                    next_state = DISCHARGING;
            end
            DISCHARGING: begin
                if (level_next == '0)
                    next_state = IDLE;
                else if (level_next == cmp_target)
                    next_state = CHARGED;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (cur_state == IDLE) && !step_set;
        state     = cur_state;
    end

endmodule

// File: tb/tb_rc_step_responder.sv
// Scoreboard bench for rc_step_responder: directed scenarios plus random step/config traffic.
module tb_rc_step_responder;

    localparam int TW  = 5;
    localparam int TRR = 5;
    localparam int MAXV = (1 << TW) - 1;

    logic       clk;
    logic       reset;
    logic       step_set;
    logic       cfg_valid;
    logic [7:0] cfg_r_code;
    logic       cfg_ready;
    logic       step_input;
    logic [1:0] state;

    rc_step_responder #(
        .W(TW), .CAP_PF(1), .LN2_X100(1), .R_RESET(TRR), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .step_set(step_set), .cfg_valid(cfg_valid),
        .cfg_r_code(cfg_r_code), .cfg_ready(cfg_ready), .step_input(step_input),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit si;
        int st;
        bit rdy;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;
    int   ncyc   = 0;

    // Reference model: charge level, threshold and hysteresis flag.
    int m_lvl  = 0;
    int m_tgt  = 0;
    bit m_high = 1'b0;

    function automatic int thr(input int code);
        int p;
        p = code * 1 * 1;
        if (p == 0) return 1;
        if (p > MAXV) return MAXV;
        return p;
    endfunction

    function automatic int mstate();
        if (m_lvl == 0) return 0;
        if (!m_high) return 1;
        return (m_lvl == m_tgt) ? 2 : 3;
    endfunction

    task automatic cyc(input bit rst, input bit ss, input bit cv, input int code);
        exp_t e;
        @(posedge clk);
        #1;
        reset      = rst;
        step_set   = ss;
        cfg_valid  = cv;
        cfg_r_code = 8'(code);
        ncyc++;
        e.st  = mstate();
        e.si  = (e.st == 2) || (e.st == 3);
        e.rdy = (e.st == 0) && !ss;
        e.cyc = ncyc;
        sb.push_back(e);
        if (rst) begin
            m_lvl  = 0;
            m_tgt  = thr(TRR);
            m_high = 1'b0;
        end else begin
            if (ss && m_lvl < m_tgt) m_lvl++;
            else if (!ss && m_lvl > 0) m_lvl--;
            if (m_lvl == m_tgt) m_high = 1'b1;
            else if (m_lvl == 0) m_high = 1'b0;
            if (cv && e.rdy) m_tgt = thr(code);
        end
    endtask

    task automatic run(input bit ss, input int n, input bit cv, input int code);
        for (int i = 0; i < n; i++) cyc(1'b0, ss, cv, code);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            if (step_input !== e.si || state !== 2'(e.st) || cfg_ready !== e.rdy) begin
                failed++;
                $display("FAIL outputs cycle %0d: got step_input=%0b state=%0d cfg_ready=%0b, expected step_input=%0b state=%0d cfg_ready=%0b",
                         e.cyc, step_input, state, cfg_ready, e.si, e.st, e.rdy);
            end
        end
    end

    initial begin
        m_tgt      = thr(TRR);
        reset      = 1'b1;
        step_set   = 1'b0;
        cfg_valid  = 1'b0;
        cfg_r_code = 8'd0;

        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0);
        run(1'b0, 2, 1'b0, 0);
        // Reset target 5: rise on 5th edge; a code offered mid-charge is ignored.
        run(1'b1, 7, 1'b1, 9);
        run(1'b0, 7, 1'b0, 0);
        // Accept code 3 in IDLE, then charge and discharge with it.
        run(1'b0, 1, 1'b1, 3);
        run(1'b1, 2, 1'b1, 9);
        run(1'b1, 3, 1'b0, 0);
        run(1'b0, 5, 1'b0, 0);
        // Partial pulse that never reaches target 10.
        run(1'b0, 1, 1'b1, 10);
        run(1'b1, 4, 1'b0, 0);
        run(1'b0, 6, 1'b0, 0);
        // Partial discharge followed by recharge.
        run(1'b1, 12, 1'b0, 0);
        run(1'b0, 4, 1'b0, 0);
        run(1'b1, 6, 1'b0, 0);
        run(1'b0, 12, 1'b0, 0);
        // Zero code forces target 1.
        run(1'b0, 1, 1'b1, 0);
        run(1'b1, 2, 1'b0, 0);
        run(1'b0, 2, 1'b0, 0);
        // Oversized code saturates the threshold.
        run(1'b0, 1, 1'b1, 40);
        run(1'b1, MAXV + 2, 1'b0, 0);
        run(1'b0, MAXV + 2, 1'b0, 0);
        // Reset while discharging.
        run(1'b0, 1, 1'b1, 7);
        run(1'b1, 8, 1'b0, 0);
        run(1'b0, 2, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0);
        run(1'b1, 6, 1'b0, 0);
        run(1'b0, 6, 1'b0, 0);
        // Random traffic.
        for (int b = 0; b < 150; b++) begin
            bit ss;
            int len;
            ss  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++)
                cyc(($urandom_range(0, 299) == 0), ss, ($urandom_range(0, 3) == 0), $urandom_range(0, 40));
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/rc_step_responder.md
Name: rc_step_responder

Overview:
- Digital stand-in for the external RC network on the step_set/step_input interface of the RC time-to-digital converter.
- Receives the excitation level step_set and drives step_input the way the RC threshold comparator would.
- step_input rises after a programmed charge time and falls after the matching discharge time.
- Used for on-chip loopback self-test and for closed-loop benches of the converter, with a programmable resistance code.

Parameters:
- W, 24, width of the charge-level counter and the threshold.
- CAP_PF, 100, emulated capacitance in pF.
- LN2_X100, 69, ln(2)*100 scaling constant.
- R_RESET, 1, resistance code loaded at reset.
- LFSR_SEED, 16'hACE1, jitter LFSR reset seed (used only when the optional feature is compiled in).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- step_set  input  1  excitation from the converter; 1 = charge, 0 = discharge.
- cfg_valid  input  1  new resistance code offered.
- cfg_r_code  input  8  resistance code, in the converter's output units.
- cfg_ready  output  1  code accepted this cycle when cfg_valid && cfg_ready.
- step_input  output  1  emulated comparator output back to the converter.
- state  output  2  current state: 0 IDLE, 1 CHARGING, 2 CHARGED, 3 DISCHARGING.

Behaviour:
- Interface: one clock domain (clk); synchronous active-high reset (reset).
- Reset values:
  - level = 0, state = IDLE, step_input = 0.
  - target = clamp(R_RESET*CAP_PF*LN2_X100).
  - cfg_ready is combinational from state, so it reads 1 out of reset.
- Threshold T = clamp(cfg_r_code*CAP_PF*LN2_X100).
  - Computed at full width, then saturated to 2^W-1.
  - A product of 0 is forced to 1.
- Config handshake:
  - cfg_ready = (state==IDLE) && !step_set.
  - On an edge with cfg_valid && cfg_ready, target <= T(cfg_r_code); it takes effect on the next charge.
  - When cfg_valid is high and cfg_ready is low, nothing is captured; the requester holds.
- Level counter, per edge:
  - step_set=1 and level<target: level+1.
  - step_set=0 and level>0: level-1.
  - Otherwise level holds; it saturates at target and at 0, with no wrap.
- State transitions (evaluated on next-level values):
  - IDLE: step_set=1 -> CHARGING (level becomes 1); if target==1 -> CHARGED directly.
  - CHARGING (step_input 0): next level==target -> CHARGED; next level==0 -> IDLE.
  - CHARGED (step_input 1): step_set=0 -> DISCHARGING (level target-1); if target==1 and level reaches 0 -> IDLE.
  - DISCHARGING (step_input 1): next level==0 -> IDLE; next level==target -> CHARGED.
- step_input is registered and changes on the same edge that enters or leaves the high states (CHARGED/DISCHARGING). This gives hysteresis: high from reaching target until reaching 0.
- Latency from a fully discharged start: step_input rises on the target-th consecutive edge with step_set sampled 1.
- Latency from a full charge: step_input falls on the target-th consecutive edge with step_set sampled 0.
- Partial pulses:
  - step_set dropping mid-charge bleeds level down with step_input staying 0.
  - step_set rising mid-discharge recharges with step_input staying 1.
- Reset mid-operation: the synchronous reset wins over every other input on that edge; all state returns to reset values.
- No overflow is possible: level never exceeds target.

Optional Feature:
- Macro: RC_JITTER_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded with LFSR_SEED at reset, advances every cycle.
  - On each IDLE->CHARGING transition, the effective target for that charge is target + lfsr[3:0], saturated at 2^W-1.
  - The effective target is held until the state returns to IDLE, so charge and discharge times match.
- Undefined: no LFSR is instantiated; the effective target equals target; all timing is exactly deterministic.

Test Plan:
- All scenarios use CAP_PF=1, LN2_X100=1, jitter off.
- Reset, then hold step_set=1 with R_RESET=5 -> step_input rises on the 5th edge; state goes 1 then 2; cfg_ready=0 throughout.
- From CHARGED with target 5, drop step_set -> state=3, step_input stays 1 for 4 edges, falls on the 5th edge; state=0; cfg_ready=1.
- In IDLE, cfg_valid with cfg_r_code=3 -> accepted; the next charge rises on edge 3. A cfg_valid with code 9 during CHARGING -> not accepted; target stays 3.
- Target 10: step_set high 4 edges then low -> level climbs to 4, bleeds to 0 in 4 edges; step_input never asserts; state returns to IDLE.
- cfg_r_code=0 -> target forced to 1: step_input rises on the 1st edge and falls 1 edge after step_set drops. Separately, with CAP_PF=100, LN2_X100=69 and cfg_r_code=255, rise occurs at 1,759,500 edges (no saturation).
- Assert reset while in DISCHARGING -> next edge: step_input=0, state=0, level=0, target=R_RESET value. With RC_JITTER_EN defined, two runs from the same seed give identical rise times.
